// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 controller: FSM states, init command ROM,
// request-bus field positions and E-strobe timing in microseconds.
package lcd_pkg;

    typedef enum logic [1:0] {
        PWR_WAIT = 2'd0,
        INIT     = 2'd1,
        READY    = 2'd2,
        SEND     = 2'd3
    } lcd_state_t;

    // Power-up command sequence, issued in this order.
    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_CLEAR    = 8'h01;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;

    // Request bus layout: {rs, rw, data[7:0]}.
    localparam int RS_BIT = 9;
    localparam int RW_BIT = 8;

    // E strobe: setup after rs/data become valid, then pulse width.
    localparam int E_SETUP_US = 1;
    localparam int E_PULSE_US = 12;

    // Init ROM lookup by command index.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = INIT_FUNC_SET;
            2'd1:    cmd = INIT_DISP_ON;
            2'd2:    cmd = INIT_CLEAR;
            default: cmd = INIT_ENTRY;
        endcase
        return cmd;
    endfunction

    // Clear (0x01) and return-home (0x02) need the long settle time.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter. done is high while the count sits at zero; the
// controller reloads on done, so within a command it marks the final cycle.
module lcd_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 write-only controller: power-up wait, fixed init sequence,
// then executes one {rs,data} word per lcd_enable while lcd_busy is low.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_MHZ  = 50,
    parameter int T_PWR_US = 50000,
    parameter int T_CMD_US = 50,
    parameter int T_CLR_US = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_enable,
    input  logic [9:0] lcd_bus,
    output logic       lcd_busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       lcd_on
);

    localparam int TW = $clog2(T_PWR_US * CLK_MHZ) + 1;

    // Timer reload values are "length - 1" so done lands on the last cycle.
    localparam logic [TW-1:0] PWR_LAST = TW'(T_PWR_US * CLK_MHZ - 1);
    localparam logic [TW-1:0] CMD_LAST = TW'(T_CMD_US * CLK_MHZ - 1);
    localparam logic [TW-1:0] CLR_LAST = TW'(T_CLR_US * CLK_MHZ - 1);
    localparam logic [TW-1:0] E_ON     = TW'(E_SETUP_US * CLK_MHZ);
    localparam logic [TW-1:0] E_OFF    = TW'((E_SETUP_US + E_PULSE_US) * CLK_MHZ);

    lcd_state_t    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] last_q, last_d;
    logic          busy_q, busy_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          on_q, on_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic [TW-1:0] tmr_count;
    logic          tmr_done;
    logic [TW-1:0] elapsed_next;
    logic          strobe_next;
    logic [1:0]    idx_next;
    logic          rw_unused;

    // The rw bit of a request is ignored: the panel is only ever written.
    assign rw_unused = lcd_bus[RW_BIT];

    function automatic logic [TW-1:0] cmd_last(input logic rs, input logic [7:0] data);
        return is_slow_cmd(rs, data) ? CLR_LAST : CMD_LAST;
    endfunction

    lcd_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    // E level for the next cycle of the current command; a finishing command
    // always hands over to a fresh command or READY, both of which start low.
    always_comb begin
        elapsed_next = last_q - tmr_count + TW'(1);
        strobe_next  = !tmr_done && (elapsed_next >= E_ON) && (elapsed_next < E_OFF);
        idx_next     = idx_q + 2'd1;
    end

    // Next-state and registered-output logic for the controller FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        busy_d   = busy_q;
        e_d      = 1'b0;
        rs_d     = rs_q;
        data_d   = data_q;
        on_d     = 1'b1;
        tmr_load = 1'b0;
        tmr_val  = last_q;
        case (state_q)
            PWR_WAIT: begin
                busy_d = 1'b1;
                if (!on_q) begin
                    // First cycle out of reset: arm the power-up wait.
                    tmr_load = 1'b1;
                    tmr_val  = PWR_LAST;
                end else if (tmr_done) begin
                    state_d  = INIT;
                    idx_d    = 2'd0;
                    rs_d     = 1'b0;
                    data_d   = init_cmd(2'd0);
                    last_d   = cmd_last(1'b0, init_cmd(2'd0));
                    tmr_load = 1'b1;
                    tmr_val  = cmd_last(1'b0, init_cmd(2'd0));
                end
            end
            INIT: begin
                e_d = strobe_next;
                if (tmr_done) begin
                    if (idx_q == 2'd3) begin
                        state_d = READY;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d    = idx_next;
                        data_d   = init_cmd(idx_next);
                        last_d   = cmd_last(1'b0, init_cmd(idx_next));
                        tmr_load = 1'b1;
                        tmr_val  = cmd_last(1'b0, init_cmd(idx_next));
                    end
                end
            end
            READY: begin
                if (lcd_enable) begin
                    state_d  = SEND;
                    busy_d   = 1'b1;
                    rs_d     = lcd_bus[RS_BIT];
                    data_d   = lcd_bus[7:0];
                    last_d   = cmd_last(lcd_bus[RS_BIT], lcd_bus[7:0]);
                    tmr_load = 1'b1;
                    tmr_val  = cmd_last(lcd_bus[RS_BIT], lcd_bus[7:0]);
                end
            end
            SEND: begin
                e_d = strobe_next;
                if (tmr_done) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = PWR_WAIT;
                busy_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any strobe in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PWR_WAIT;
            idx_q   <= 2'd0;
            last_q  <= '0;
            busy_q  <= 1'b1;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            on_q    <= on_d;
        end
    end

    assign lcd_busy = busy_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = data_q;
    assign lcd_on   = on_q;

endmodule
